bcmp_bist: RTL

BCMP_BIST -- requirements
Module: bcmp_bist

---
 rtl/bcmp_bist.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcmp_bist.sv
// Exhaustive BIST for a 2-bit magnitude comparator: sweeps all 16 {X,Y} pairs and counts wrong responses.
// Optional first-failure capture is compiled in with `define BCMP_BIST_CAPTURE_EN.
module bcmp_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [4:0] err_q, err_d;
    logic       launch;
    logic       miss;
    logic [1:0] op_x, op_y;
    logic [2:0] exp_resp;

    assign op_x     = vec_q[3:2];
    assign op_y     = vec_q[1:0];
    assign exp_resp = {op_x > op_y, op_x == op_y, op_x < op_y};
    assign launch   = start && (state_q == IDLE || state_q == DONE);
    // Any response other than the exact one-hot pattern is a failure.
    assign miss     = (state_q == CHECK) && ({f1, f2, f3} != exp_resp);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   if (settle_q == SETTLE_LAST) state_d = CHECK;
            CHECK:   state_d = (vec_q == 4'd15) ? DONE : DRIVE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {a, b, c, d} = 4'b0000;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            DRIVE, CHECK: begin
                {a, b, c, d} = vec_q;
                busy         = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        if (launch) begin
            vec_d    = 4'd0;
            settle_d = 4'd0;
            err_d    = 5'd0;
        end else if (state_q == DRIVE) begin
            settle_d = (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
        end else if (state_q == CHECK) begin
            if (miss) err_d = err_q + 5'd1;
            if (vec_q != 4'd15) vec_d = vec_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q    <= 4'd0;
            settle_q <= 4'd0;
            err_q    <= 5'd0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
        end
    end

    assign err_cnt = err_q;
    assign pass    = done && (err_q == 5'd0);

`ifdef BCMP_BIST_CAPTURE_EN
    logic [3:0] fail_vec_q;
    logic       fail_valid_q;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            fail_vec_q   <= 4'd0;
            fail_valid_q <= 1'b0;
        end else if (miss && !fail_valid_q) begin
            fail_vec_q   <= vec_q;
            fail_valid_q <= 1'b1;
        end
    end

    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`else
    assign fail_vec   = 4'd0;
    assign fail_valid = 1'b0;
`endif

endmodule
